// File: rtl/pwm_decoder_if.sv
// Signal bundle for the PWM decoder: the raw PWM line in, decoded duty count and status out.
interface pwm_decoder_if #(
    parameter int WIDTH = 8
);
    logic             pwm_in;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             locked;
    logic             err;

    modport master (output pwm_in, input value, valid, locked, err);
    modport slave  (input pwm_in, output value, valid, locked, err);
endinterface

// File: rtl/pwm_decoder.sv
// Decodes a fixed-period PWM line (period 2**WIDTH clocks) into its duty count N,
// locking onto rising edges and flagging frames that break the framing rules.
module pwm_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic          clk,
    input  logic          reset,
    pwm_decoder_if.slave  bus
);
    localparam int unsigned      P     = 2 ** WIDTH;
    localparam logic [WIDTH:0]   L_MAX = (WIDTH + 1)'(P);
    localparam logic [WIDTH-1:0] H_MAX = '1;
    localparam logic [0:0]       HUNT    = 1'b0;
    localparam logic [0:0]       MEASURE = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   s_prev_q;
    logic                   s;
    logic                   rise;

    logic [0:0]       state_q, state_d;
    logic [WIDTH:0]   l_q, l_d;
    logic [WIDTH-1:0] h_q, h_d, h_inc;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;

    assign s = sync_q[SYNC_STAGES-1];
    // fill_q marks when s_prev_q holds a real pin sample, so a line already high
    // at reset release is not mistaken for a rise against the cleared history.
    assign rise  = s & ~s_prev_q & fill_q[SYNC_STAGES];
    assign h_inc = (s && (h_q != H_MAX)) ? h_q + 1'b1 : h_q;

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        h_d      = h_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        case (state_q)
            HUNT: begin
                if (rise) begin
                    state_d = MEASURE;
                    l_d     = (WIDTH + 1)'(1);
                    h_d     = (WIDTH)'(1);
                end
            end
            MEASURE: begin
                if (l_q == L_MAX) begin
                    if (s && !rise) begin
                        // Line stayed high across the boundary: no valid frame ends here.
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = HUNT;
                        l_d      = '0;
                        h_d      = '0;
                    end else begin
                        value_d  = h_q;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                        l_d      = (WIDTH + 1)'(1);
                        h_d      = {{(WIDTH - 1){1'b0}}, s};
                    end
                end else if (rise) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    l_d      = (WIDTH + 1)'(1);
                    h_d      = (WIDTH)'(1);
                end else begin
                    l_d = l_q + 1'b1;
                    h_d = h_inc;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            fill_q   <= '0;
            s_prev_q <= 1'b0;
            state_q  <= HUNT;
            l_q      <= '0;
            h_q      <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            s_prev_q <= s;
            state_q  <= state_d;
            l_q      <= l_d;
            h_q      <= h_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign bus.value  = value_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.locked = locked_q;
endmodule
